rtl_operand_queue: RTL and testbench



---
 rtl/rtl_operand_queue_if.sv | 26 ++
 rtl/rtl_operand_queue.sv | 89 ++++++++
 tb/tb_rtl_operand_queue.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rtl_operand_queue_if.sv
// Ready/valid operand channels for rtl_operand_queue: producer-side enqueue
// and consumer-side dequeue of (in1, in2) pairs.
interface rtl_operand_queue_if #(
  parameter int WIDTH = 4
);
  logic             enq_valid;
  logic             enq_ready;
  logic [WIDTH-1:0] enq_in1;
  logic [WIDTH-1:0] enq_in2;
  logic             deq_valid;
  logic             deq_ready;
  logic [WIDTH-1:0] deq_in1;
  logic [WIDTH-1:0] deq_in2;

  // Environment side: drives the producer data and the consumer ready
  modport master (
    output enq_valid, enq_in1, enq_in2, deq_ready,
    input  enq_ready, deq_valid, deq_in1, deq_in2
  );

  // Queue side
  modport slave (
    input  enq_valid, enq_in1, enq_in2, deq_ready,
    output enq_ready, deq_valid, deq_in1, deq_in2
  );
endinterface

// File: rtl/rtl_operand_queue.sv
// DEPTH-entry circular FIFO of operand pairs feeding the foo_RTL stage, with
// occupancy and a saturating producer-stall counter for debug.
module rtl_operand_queue #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                       CLK,
  input  logic                       RESET,
  rtl_operand_queue_if.slave         io,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_WIDTH-1:0]       stall_cycles
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]        FULL_CNT  = CW'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] STALL_MAX = '1;

  logic [2*WIDTH-1:0]   mem_q [DEPTH];
  logic [2*WIDTH-1:0]   mem_d [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;

  logic enq_fire;
  logic deq_fire;

  // Readiness comes only from registered occupancy, so a full queue refuses
  // an enqueue even when a dequeue fires in the same cycle.
  always_comb begin
    io.enq_ready = !RESET && (count_q != FULL_CNT);
    io.deq_valid = !RESET && (count_q != '0);
    if (io.deq_valid) begin
      io.deq_in1 = mem_q[rd_ptr_q][2*WIDTH-1:WIDTH];
      io.deq_in2 = mem_q[rd_ptr_q][WIDTH-1:0];
    end else begin
      io.deq_in1 = '0;
      io.deq_in2 = '0;
    end
  end

  assign enq_fire     = io.enq_valid && io.enq_ready;
  assign deq_fire     = io.deq_valid && io.deq_ready;
  assign count        = count_q;
  assign stall_cycles = stall_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;

    if (enq_fire) begin
      mem_d[wr_ptr_q] = {io.enq_in1, io.enq_in2};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (deq_fire) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (io.enq_valid && !io.enq_ready && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + CNT_WIDTH'(1);
    end
  end

  // Storage is left untouched on reset; emptiness is tracked by count alone.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end
endmodule

// File: tb/tb_rtl_operand_queue.sv
// Directed bench for rtl_operand_queue: a queue-based reference model is
// compared every cycle, plus literal checks at the interesting points.
module tb_rtl_operand_queue;
  localparam int W     = 4;
  localparam int DEPTH = 4;
  localparam int CNTW  = 4;
  localparam int SMAX  = (1 << CNTW) - 1;

  logic            CLK;
  logic            RESET;
  logic [$clog2(DEPTH):0] count;
  logic [CNTW-1:0] stall_cycles;

  rtl_operand_queue_if #(.WIDTH(W)) bus ();

  rtl_operand_queue #(
    .WIDTH    (W),
    .DEPTH    (DEPTH),
    .CNT_WIDTH(CNTW)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .io          (bus),
    .count       (count),
    .stall_cycles(stall_cycles)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests  = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {in1,in2} pairs plus a stall count.
  logic [2*W-1:0] mq[$];
  int             mstall = 0;
  bit             started = 1'b0;

  always @(posedge CLK) begin
    bit rdy, vld;
    if (RESET) begin
      mq.delete();
      mstall = 0;
    end else begin
      rdy = (mq.size() != DEPTH);
      vld = (mq.size() != 0);
      if (bus.enq_valid && !rdy && mstall != SMAX) mstall++;
      if (vld && bus.deq_ready) void'(mq.pop_front());
      if (bus.enq_valid && rdy) mq.push_back({bus.enq_in1, bus.enq_in2});
    end
  end

  always @(negedge CLK) begin
    int e_rdy, e_vld, e_in1, e_in2;
    if (started) begin
      e_rdy = (!RESET && mq.size() != DEPTH) ? 1 : 0;
      e_vld = (!RESET && mq.size() != 0) ? 1 : 0;
      e_in1 = e_vld ? int'(mq[0][2*W-1:W]) : 0;
      e_in2 = e_vld ? int'(mq[0][W-1:0]) : 0;
      chk("m_enq_ready", bus.enq_ready, e_rdy);
      chk("m_deq_valid", bus.deq_valid, e_vld);
      chk("m_deq_in1", bus.deq_in1, e_in1);
      chk("m_deq_in2", bus.deq_in2, e_in2);
      chk("m_count", count, RESET ? int'(count) : mq.size());
      chk("m_stall", stall_cycles, mstall);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
  endtask

  initial begin
    RESET         = 1'b1;
    bus.enq_valid = 1'b0;
    bus.enq_in1   = '0;
    bus.enq_in2   = '0;
    bus.deq_ready = 1'b0;
    step();
    started = 1'b1;
    step();
    chk("rst_enq_ready", bus.enq_ready, 0);
    chk("rst_deq_valid", bus.deq_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_stall", stall_cycles, 0);
    RESET = 1'b0;
    #1;
    chk("post_rst_enq_ready", bus.enq_ready, 1);
    chk("post_rst_deq_valid", bus.deq_valid, 0);

    // Single pair, 1-cycle latency, then drain
    bus.enq_valid = 1'b1; bus.enq_in1 = 4'h3; bus.enq_in2 = 4'h5;
    step();
    bus.enq_valid = 1'b0;
    chk("t1_deq_valid", bus.deq_valid, 1);
    chk("t1_in1", bus.deq_in1, 3);
    chk("t1_in2", bus.deq_in2, 5);
    chk("t1_count", count, 1);
    bus.deq_ready = 1'b1;
    step();
    bus.deq_ready = 1'b0;
    chk("t1_count_drained", count, 0);
    chk("t1_valid_drained", bus.deq_valid, 0);
    chk("t1_in1_zero", bus.deq_in1, 0);
    chk("t1_in2_zero", bus.deq_in2, 0);

    // Fill, then stall three cycles
    for (int i = 1; i <= 4; i++) begin
      bus.enq_valid = 1'b1; bus.enq_in1 = W'(i); bus.enq_in2 = W'(i);
      step();
    end
    chk("t2_count_full", count, 4);
    chk("t2_enq_ready", bus.enq_ready, 0);
    bus.enq_in1 = 4'h9; bus.enq_in2 = 4'h9;
    for (int i = 0; i < 3; i++) step();
    chk("t2_stall", stall_cycles, 3);
    chk("t2_head", bus.deq_in1, 1);

    // Full + simultaneous dequeue: enqueue refused this edge
    bus.enq_in1 = 4'h5; bus.enq_in2 = 4'h5; bus.deq_ready = 1'b1;
    step();
    chk("t3_count", count, 3);
    chk("t3_head", bus.deq_in1, 2);
    bus.deq_ready = 1'b0;
    step();
    chk("t3_count_refill", count, 4);
    bus.enq_valid = 1'b0; bus.deq_ready = 1'b1;
    for (int e = 2; e <= 5; e++) begin
      chk("t3_drain", bus.deq_in1, e);
      step();
    end
    chk("t3_empty", count, 0);

    // Streaming with pointer wrap
    bus.enq_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.enq_in1 = W'(i); bus.enq_in2 = ~W'(i);
      step();
      chk("t4_count", count, 1);
      chk("t4_in1", bus.deq_in1, i % 16);
      chk("t4_in2", bus.deq_in2, 15 - (i % 16));
    end
    bus.enq_valid = 1'b0;
    step();
    chk("t4_empty", count, 0);

    // Stall counter saturation
    do_reset();
    bus.deq_ready = 1'b0; bus.enq_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.enq_in1 = W'(8 + i); bus.enq_in2 = W'(i);
      step();
    end
    for (int i = 0; i < 20; i++) step();
    chk("t5_stall_sat", stall_cycles, 15);
    step(); step();
    chk("t5_stall_held", stall_cycles, 15);
    chk("t5_head", bus.deq_in1, 8);

    // Reset mid-operation with count=3
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.enq_in1 = W'(10 + i); bus.enq_in2 = W'(10 + i);
      step();
    end
    chk("t6_count3", count, 3);
    bus.enq_in1 = 4'hF; bus.enq_in2 = 4'hF; bus.deq_ready = 1'b1;
    RESET = 1'b1;
    #1;
    chk("t6_rst_enq_ready", bus.enq_ready, 0);
    chk("t6_rst_deq_valid", bus.deq_valid, 0);
    step();
    RESET = 1'b0; bus.enq_valid = 1'b0;
    #1;
    chk("t6_count", count, 0);
    chk("t6_stall", stall_cycles, 0);
    chk("t6_deq_valid", bus.deq_valid, 0);
    chk("t6_in1", bus.deq_in1, 0);
    step(); step();
    bus.deq_ready = 1'b0; bus.enq_valid = 1'b1;
    bus.enq_in1 = 4'h6; bus.enq_in2 = 4'h7;
    step();
    bus.enq_valid = 1'b0;
    chk("t6_new_in1", bus.deq_in1, 6);
    chk("t6_new_in2", bus.deq_in2, 7);
    chk("t6_new_count", count, 1);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
